cpl_data_packer: RTL and testbench

Receives PCIe completion TLPs from the 64-bit endpoint RX AXI-Stream, strips 3DW CplD headers, and repacks payload DWs into 128-bit words with per-DW enables. It sits directly upstream of the DMA read controller and drives its `packer_*` inputs: each output word is tagged with its completion's tag, and the final completion of a read request is flagged. Non-completion TLPs are consumed and discarded.

---
 rtl/cpl_packer_pkg.sv | 37 +++
 rtl/cpl_dw_accumulator.sv | 112 +++++++++++
 rtl/cpl_data_packer.sv | 180 ++++++++++++++++++
 tb/tb_cpl_data_packer.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpl_packer_pkg.sv
// Shared constants and types for the completion data packer.
// Holds TLP fmt/type codes, completion status codes, the header FSM state
// type and the DW-count to thermometer-enable helper.
package cpl_packer_pkg;

    localparam logic [2:0] FMT_3DW_NODATA = 3'b000;
    localparam logic [2:0] FMT_3DW_DATA   = 3'b010;
    localparam logic [4:0] TYPE_CPL       = 5'b01010;

    // fmt/type byte as it appears in header DW0[31:24]
    localparam logic [7:0] FT_CPLD = {FMT_3DW_DATA, TYPE_CPL};
    localparam logic [7:0] FT_CPL  = {FMT_3DW_NODATA, TYPE_CPL};

    localparam logic [2:0] CPL_STATUS_SC  = 3'b000;
    localparam logic [2:0] CPL_STATUS_UR  = 3'b001;
    localparam logic [2:0] CPL_STATUS_CRS = 3'b010;
    localparam logic [2:0] CPL_STATUS_CA  = 3'b100;

    typedef enum logic [1:0] {
        ST_HDR0 = 2'd0,
        ST_HDR1 = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } cpl_state_e;

    // Number of valid DWs in an output word -> thermometer DW enables.
    function automatic logic [3:0] dw_cnt_to_dwen(input logic [2:0] dw_cnt);
        case (dw_cnt)
            3'd0:    return 4'b0000;
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0011;
            3'd3:    return 4'b0111;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/cpl_dw_accumulator.sv
// Payload DW accumulator: holds 0-3 pending DWs, accepts 1 or 2 new DWs per
// cycle and emits registered 128-bit words with thermometer DW enables.
// A flush closes the current completion; if that leaves 5 DWs, a full word
// goes out immediately and the single leftover DW follows one cycle later.
module cpl_dw_accumulator
    import cpl_packer_pkg::*;
#(
    parameter int P_TAG_WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [1:0]             push_cnt,
    input  logic [63:0]            push_data,
    input  logic                   flush,
    input  logic                   done_in,
    input  logic [P_TAG_WIDTH-1:0] tag_in,
    output logic [127:0]           dout,
    output logic [3:0]             dwen,
    output logic                   valid,
    output logic                   done,
    output logic [P_TAG_WIDTH-1:0] tag
);

    logic [95:0]            hold_q;
    logic [1:0]             hold_cnt_q;
    logic                   ovf_q;
    logic [31:0]            ovf_dw_q;
    logic                   ovf_done_q;
    logic [P_TAG_WIDTH-1:0] ovf_tag_q;

    logic [63:0]            push_masked;
    logic [159:0]           merged;
    logic [2:0]             total;

    // Append incoming DWs behind the held ones, lowest address first.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        push_masked = 64'd0;
        case (push_cnt)
            2'd1:    push_masked = {32'd0, push_data[31:0]};
            2'd2:    push_masked = push_data;
            default: push_masked = 64'd0;
        endcase
        merged = {64'd0, hold_q} | ({96'd0, push_masked} << {hold_cnt_q, 5'd0});
        total  = {1'b0, hold_cnt_q} + {1'b0, push_cnt};
    end

    // Word emission, remainder bookkeeping and the deferred overflow word.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            // NOTE: the holding buffer is cleared on reset so stale DWs never reappear in padding lanes.
            hold_q     <= '0;
            hold_cnt_q <= '0;
            ovf_q      <= 1'b0;
            ovf_dw_q   <= '0;
            ovf_done_q <= 1'b0;
            ovf_tag_q  <= '0;
            dout       <= '0;
            dwen       <= '0;
            valid      <= 1'b0;
            done       <= 1'b0;
            tag        <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            valid <= 1'b0;
            done  <= 1'b0;
            ovf_q <= 1'b0;
            if (ovf_q) begin
                // Header beat of the next TLP carries no payload, so this slot is free.
                dout  <= {96'd0, ovf_dw_q};
                dwen  <= 4'b0001;
                valid <= 1'b1;
                done  <= ovf_done_q;
                tag   <= ovf_tag_q;
            end else if (total >= 3'd4) begin
                dout  <= merged[127:0];
                dwen  <= 4'b1111;
                valid <= 1'b1;
                tag   <= tag_in;
                if (flush) begin
                    hold_q     <= '0;
                    hold_cnt_q <= '0;
                    if (total == 3'd5) begin
                        ovf_q      <= 1'b1;
                        ovf_dw_q   <= merged[159:128];
                        ovf_done_q <= done_in;
                        ovf_tag_q  <= tag_in;
                    end else begin
                        done <= done_in;
                    end
                end else begin
                    hold_q     <= {64'd0, merged[159:128]};
                    hold_cnt_q <= 2'(total - 3'd4);
                end
            end else if (flush) begin
                hold_q     <= '0;
                hold_cnt_q <= '0;
                if (total != 3'd0) begin
                    dout  <= merged[127:0];
                    dwen  <= dw_cnt_to_dwen(total);
                    valid <= 1'b1;
                    done  <= done_in;
                    tag   <= tag_in;
                end
            end else begin
                hold_q     <= merged[95:0];
                hold_cnt_q <= total[1:0];
            end
        end
    end

endmodule

// File: rtl/cpl_data_packer.sv
// Completion data packer: strips 3DW CplD headers from the 64-bit RX stream
// and repacks payload DWs into 128-bit words for the DMA read controller.
// Non-completion TLPs are consumed and discarded; the block never stalls.
// Optional feature macro: CPL_PACKER_STATUS_CHECK_EN drops CplDs whose
// status is not SC or whose EP bit is set, pulsing cpl_err on their tlast.
module cpl_data_packer
    import cpl_packer_pkg::*;
#(
    parameter int P_TAG_WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [63:0]            rx_tdata,
    input  logic [7:0]             rx_tkeep,
    input  logic                   rx_tlast,
    input  logic                   rx_tvalid,
    output logic                   rx_tready,
    output logic [P_TAG_WIDTH-1:0] packer_tag,
    output logic [127:0]           packer_dout,
    output logic [3:0]             packer_dout_dwen,
    output logic                   packer_valid,
    output logic                   packer_done,
    output logic                   cpl_err
);

    cpl_state_e             state_q, state_d;
    logic [10:0]            rem_q, rem_d;
    logic                   final_q, final_d;
    logic [P_TAG_WIDTH-1:0] tag_q, tag_d;
    logic                   over_q, over_d;
    logic                   drop_err_q, drop_err_d;
    logic                   err_q, err_d;

    logic                   beat;
    logic                   full_beat;
    logic                   is_cpld;
    logic                   status_bad;
    logic [10:0]            len_eff;
    logic [12:0]            bc_eff;
    logic [1:0]             avail;
    logic [1:0]             take;
    logic [10:0]            rem_after;
    logic                   excess;

    logic [1:0]             push_cnt;
    logic [63:0]            push_data;
    logic                   flush;
    logic                   done_in;
    logic [P_TAG_WIDTH-1:0] acc_tag;

    assign rx_tready = ~i_rst;
    assign beat      = rx_tvalid & rx_tready;
    assign full_beat = (rx_tkeep == 8'hFF);

    // Header beat 0 fields: DW0 fmt/type and length, DW1 byte count.
    assign is_cpld = (rx_tdata[31:24] == FT_CPLD);
    assign len_eff = (rx_tdata[9:0] == 10'd0) ? 11'd1024 : {1'b0, rx_tdata[9:0]};
    assign bc_eff  = (rx_tdata[43:32] == 12'd0) ? 13'd4096 : {1'b0, rx_tdata[43:32]};

`ifdef CPL_PACKER_STATUS_CHECK_EN
    logic [2:0] hdr_status;
    logic       hdr_ep;
    assign hdr_status = rx_tdata[47:45];
    assign hdr_ep     = rx_tdata[14];
    assign status_bad = (hdr_status != CPL_STATUS_SC) || hdr_ep;
`else
    assign status_bad = 1'b0;
`endif

    // Header decode, payload DW accounting and length-mismatch detection.
    always_comb begin
        state_d    = state_q;
        rem_d      = rem_q;
        final_d    = final_q;
        tag_d      = tag_q;
        over_d     = over_q;
        drop_err_d = drop_err_q;
        err_d      = 1'b0;
        push_cnt   = 2'd0;
        push_data  = rx_tdata;
        flush      = 1'b0;
        done_in    = 1'b0;
        acc_tag    = tag_q;
        avail      = 2'd0;
        take       = 2'd0;
        rem_after  = rem_q;
        excess     = 1'b0;
        if (beat) begin
            case (state_q)
                ST_HDR0: begin
                    rem_d      = len_eff;
                    final_d    = (bc_eff == {len_eff, 2'b00});
                    over_d     = 1'b0;
                    drop_err_d = 1'b0;
                    if (is_cpld && !status_bad) begin
                        state_d = rx_tlast ? ST_HDR0 : ST_HDR1;
                    end else begin
                        state_d    = rx_tlast ? ST_HDR0 : ST_DROP;
                        drop_err_d = is_cpld;
                        err_d      = rx_tlast && is_cpld;
                    end
                end
                ST_HDR1, ST_DATA: begin
                    if (state_q == ST_HDR1) begin
                        tag_d     = P_TAG_WIDTH'(rx_tdata[15:8]);
                        push_data = {32'd0, rx_tdata[63:32]};
                        avail     = full_beat ? 2'd1 : 2'd0;
                    end else begin
                        avail     = full_beat ? 2'd2 : 2'd1;
                    end
                    acc_tag   = tag_d;
                    excess    = ({9'd0, avail} > rem_q);
                    take      = excess ? rem_q[1:0] : avail;
                    rem_after = rem_q - {9'd0, take};
                    push_cnt  = take;
                    rem_d     = rem_after;
                    if (rx_tlast) begin
                        flush   = 1'b1;
                        done_in = final_q && (rem_after == 11'd0);
                        err_d   = (rem_after != 11'd0) || over_q || excess;
                        over_d  = 1'b0;
                        state_d = ST_HDR0;
                    end else begin
                        over_d  = over_q || excess;
                        state_d = ST_DATA;
                    end
                end
                ST_DROP: begin
                    if (rx_tlast) begin
                        err_d      = drop_err_q;
                        drop_err_d = 1'b0;
                        state_d    = ST_HDR0;
                    end
                end
                default: state_d = ST_HDR0;
            endcase
        end
    end

    // Parser state registers and the registered error pulse.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_HDR0;
            rem_q      <= '0;
            final_q    <= 1'b0;
            tag_q      <= '0;
            over_q     <= 1'b0;
            drop_err_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rem_q      <= rem_d;
            final_q    <= final_d;
            tag_q      <= tag_d;
            over_q     <= over_d;
            drop_err_q <= drop_err_d;
            err_q      <= err_d;
        end
    end

    assign cpl_err = err_q;

    cpl_dw_accumulator #(
        .P_TAG_WIDTH (P_TAG_WIDTH)
    ) u_acc (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .push_cnt  (push_cnt),
        .push_data (push_data),
        .flush     (flush),
        .done_in   (done_in),
        .tag_in    (acc_tag),
        .dout      (packer_dout),
        .dwen      (packer_dout_dwen),
        .valid     (packer_valid),
        .done      (packer_done),
        .tag       (packer_tag)
    );

endmodule

// File: tb/tb_cpl_data_packer.sv
// Self-checking bench for cpl_data_packer: a table of per-cycle beats with
// hand-computed expected outputs, plus a long 1024-DW completion sequence.
// Outputs are sampled 1 time unit after each rising edge.
module tb_cpl_data_packer;

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b1;
    logic [63:0]  rx_tdata = '0;
    logic [7:0]   rx_tkeep = 8'hFF;
    logic         rx_tlast = 1'b0;
    logic         rx_tvalid = 1'b0;
    logic         rx_tready;
    logic [7:0]   packer_tag;
    logic [127:0] packer_dout;
    logic [3:0]   packer_dout_dwen;
    logic         packer_valid;
    logic         packer_done;
    logic         cpl_err;

    int checks = 0;
    int failures = 0;

    cpl_data_packer #(.P_TAG_WIDTH(8)) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .rx_tdata         (rx_tdata),
        .rx_tkeep         (rx_tkeep),
        .rx_tlast         (rx_tlast),
        .rx_tvalid        (rx_tvalid),
        .rx_tready        (rx_tready),
        .packer_tag       (packer_tag),
        .packer_dout      (packer_dout),
        .packer_dout_dwen (packer_dout_dwen),
        .packer_valid     (packer_valid),
        .packer_done      (packer_done),
        .cpl_err          (cpl_err)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic         rst;
        logic         valid;
        logic         last;
        logic [7:0]   keep;
        logic [63:0]  data;
        logic         ev;
        logic [3:0]   edwen;
        logic [127:0] edout;
        logic [7:0]   etag;
        logic         edone;
        logic         eerr;
    } vec_t;

    vec_t vecs[$];

    localparam logic [7:0] FT_CPLD = 8'h4A;
    localparam logic [7:0] FT_CPL  = 8'h0A;
    localparam logic [7:0] FT_MWR  = 8'h40;
    localparam logic [7:0] FT_MRD  = 8'h00;
    localparam logic [31:0] JUNK   = 32'hFFFF_FFFF;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Header beat 0: DW0 {fmt/type, TD/EP, length}, DW1 {cpl id, status, bcm, byte count}.
    function automatic logic [63:0] h0(input logic [7:0] ft, input logic [9:0] len,
                                       input logic [2:0] st, input logic ep, input logic [11:0] bc);
        logic [31:0] d0, d1;
        d0 = {ft, 8'h00, 1'b0, ep, 4'h0, len};
        d1 = {16'h0100, st, 1'b0, bc};
        return {d1, d0};
    endfunction

    // Header beat 1: DW2 {requester id, tag, lower addr}, DW3 first payload DW.
    function automatic logic [63:0] h1(input logic [7:0] tg, input logic [31:0] dw3);
        return {dw3, 16'hBEEF, tg, 8'h00};
    endfunction

    function automatic logic [31:0] pd(input logic [7:0] id, input logic [7:0] k);
        return {id, 8'h5A, 8'h00, k};
    endfunction

    task automatic add(input logic rst, input logic valid, input logic last, input logic [7:0] keep,
                       input logic [63:0] data, input logic ev, input logic [3:0] edwen,
                       input logic [127:0] edout, input logic [7:0] etag, input logic edone,
                       input logic eerr);
        vec_t v;
        v.rst = rst; v.valid = valid; v.last = last; v.keep = keep; v.data = data;
        v.ev = ev; v.edwen = edwen; v.edout = edout; v.etag = etag; v.edone = edone; v.eerr = eerr;
        vecs.push_back(v);
    endtask

    task automatic quiet(input logic valid, input logic last, input logic [7:0] keep,
                         input logic [63:0] data, input logic eerr);
        add(1'b0, valid, last, keep, data, 1'b0, 4'h0, 128'd0, 8'h00, 1'b0, eerr);
    endtask

    // Long-completion counters
    int words = 0;
    int dones = 0;
    int done_word = -1;
    int errs = 0;
    int content_bad = 0;

    task automatic step(input logic valid, input logic last, input logic [7:0] keep, input logic [63:0] data);
        logic [31:0] k;
        rx_tvalid = valid; rx_tlast = last; rx_tkeep = keep; rx_tdata = data;
        @(posedge i_clk); #1;
        if (cpl_err) errs++;
        if (packer_valid) begin
            k = 32'(words * 4);
            if (packer_dout !== {k + 32'd3, k + 32'd2, k + 32'd1, k} || packer_dout_dwen !== 4'b1111
                || packer_tag !== 8'h88)
                content_bad++;
            if (packer_done) begin
                dones++;
                done_word = words;
            end
            words++;
        end
    endtask

    initial begin
        vec_t v;

        // CplD tag 05, len 8, bc 32 (final), with an idle cycle mid-TLP
        quiet(1, 0, 8'hFF, h0(FT_CPLD, 10'd8, 3'b000, 1'b0, 12'd32), 0);
        quiet(1, 0, 8'hFF, h1(8'h05, pd(1, 0)), 0);
        quiet(1, 0, 8'hFF, {pd(1, 2), pd(1, 1)}, 0);
        add(0, 1, 0, 8'hFF, {pd(1, 4), pd(1, 3)}, 1, 4'b1111,
            {pd(1, 3), pd(1, 2), pd(1, 1), pd(1, 0)}, 8'h05, 0, 0);
        quiet(0, 0, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 0);
        quiet(1, 0, 8'hFF, {pd(1, 6), pd(1, 5)}, 0);
        add(0, 1, 1, 8'h0F, {JUNK, pd(1, 7)}, 1, 4'b1111,
            {pd(1, 7), pd(1, 6), pd(1, 5), pd(1, 4)}, 8'h05, 1, 0);

        // CplD tag 12, len 6, bc 64 (non-final)
        quiet(1, 0, 8'hFF, h0(FT_CPLD, 10'd6, 3'b000, 1'b0, 12'd64), 0);
        quiet(1, 0, 8'hFF, h1(8'h12, pd(2, 0)), 0);
        quiet(1, 0, 8'hFF, {pd(2, 2), pd(2, 1)}, 0);
        add(0, 1, 0, 8'hFF, {pd(2, 4), pd(2, 3)}, 1, 4'b1111,
            {pd(2, 3), pd(2, 2), pd(2, 1), pd(2, 0)}, 8'h12, 0, 0);
        add(0, 1, 1, 8'h0F, {JUNK, pd(2, 5)}, 1, 4'b0011,
            {64'd0, pd(2, 5), pd(2, 4)}, 8'h12, 0, 0);

        // CplD tag 21, len 5: overflow word on the next TLP's header beat
        quiet(1, 0, 8'hFF, h0(FT_CPLD, 10'd5, 3'b000, 1'b0, 12'd20), 0);
        quiet(1, 0, 8'hFF, h1(8'h21, pd(3, 0)), 0);
        quiet(1, 0, 8'hFF, {pd(3, 2), pd(3, 1)}, 0);
        add(0, 1, 1, 8'hFF, {pd(3, 4), pd(3, 3)}, 1, 4'b1111,
            {pd(3, 3), pd(3, 2), pd(3, 1), pd(3, 0)}, 8'h21, 0, 0);
        add(0, 1, 0, 8'hFF, h0(FT_CPLD, 10'd2, 3'b000, 1'b0, 12'd8), 1, 4'b0001,
            {96'd0, pd(3, 4)}, 8'h21, 1, 0);
        quiet(1, 0, 8'hFF, h1(8'h22, pd(4, 0)), 0);
        add(0, 1, 1, 8'h0F, {JUNK, pd(4, 1)}, 1, 4'b0011,
            {64'd0, pd(4, 1), pd(4, 0)}, 8'h22, 1, 0);

        // MWr, MRd and a data-less Cpl are discarded
        quiet(1, 0, 8'hFF, h0(FT_MWR, 10'd2, 3'b000, 1'b0, 12'd0), 0);
        quiet(1, 0, 8'hFF, {pd(9, 0), 32'h1000_0000}, 0);
        quiet(1, 1, 8'h0F, {JUNK, pd(9, 1)}, 0);
        quiet(1, 0, 8'hFF, h0(FT_MRD, 10'd1, 3'b000, 1'b0, 12'd0), 0);
        quiet(1, 1, 8'h0F, {JUNK, 32'h2000_0000}, 0);
        quiet(1, 0, 8'hFF, h0(FT_CPL, 10'd0, 3'b000, 1'b0, 12'd4), 0);
        quiet(1, 1, 8'h0F, {JUNK, 32'h0000_3300}, 0);
        quiet(1, 0, 8'hFF, h0(FT_CPLD, 10'd4, 3'b000, 1'b0, 12'd16), 0);
        quiet(1, 0, 8'hFF, h1(8'h33, pd(5, 0)), 0);
        quiet(1, 0, 8'hFF, {pd(5, 2), pd(5, 1)}, 0);
        add(0, 1, 1, 8'h0F, {JUNK, pd(5, 3)}, 1, 4'b1111,
            {pd(5, 3), pd(5, 2), pd(5, 1), pd(5, 0)}, 8'h33, 1, 0);

        // Status UR (tag 44) and EP=1 (tag 45)
        quiet(1, 0, 8'hFF, h0(FT_CPLD, 10'd2, 3'b001, 1'b0, 12'd8), 0);
        quiet(1, 0, 8'hFF, h1(8'h44, pd(6, 0)), 0);
`ifdef CPL_PACKER_STATUS_CHECK_EN
        quiet(1, 1, 8'h0F, {JUNK, pd(6, 1)}, 1);
        quiet(1, 0, 8'hFF, h0(FT_CPLD, 10'd1, 3'b000, 1'b1, 12'd4), 0);
        quiet(1, 1, 8'hFF, h1(8'h45, pd(7, 0)), 1);
`else
        add(0, 1, 1, 8'h0F, {JUNK, pd(6, 1)}, 1, 4'b0011,
            {64'd0, pd(6, 1), pd(6, 0)}, 8'h44, 1, 0);
        quiet(1, 0, 8'hFF, h0(FT_CPLD, 10'd1, 3'b000, 1'b1, 12'd4), 0);
        add(0, 1, 1, 8'hFF, h1(8'h45, pd(7, 0)), 1, 4'b0001,
            {96'd0, pd(7, 0)}, 8'h45, 1, 0);
`endif

        // Early tlast: 3 of 4 DWs, no done, error pulse
        quiet(1, 0, 8'hFF, h0(FT_CPLD, 10'd4, 3'b000, 1'b0, 12'd16), 0);
        quiet(1, 0, 8'hFF, h1(8'h55, pd(8, 0)), 0);
        add(0, 1, 1, 8'hFF, {pd(8, 2), pd(8, 1)}, 1, 4'b0111,
            {32'd0, pd(8, 2), pd(8, 1), pd(8, 0)}, 8'h55, 0, 1);

        // Excess DW beyond length 2 is dropped, error pulse
        quiet(1, 0, 8'hFF, h0(FT_CPLD, 10'd2, 3'b000, 1'b0, 12'd8), 0);
        quiet(1, 0, 8'hFF, h1(8'h56, pd(10, 0)), 0);
        add(0, 1, 1, 8'hFF, {pd(10, 2), pd(10, 1)}, 1, 4'b0011,
            {64'd0, pd(10, 1), pd(10, 0)}, 8'h56, 1, 1);

        // Length 1, payload and tlast on header beat 1
        quiet(1, 0, 8'hFF, h0(FT_CPLD, 10'd1, 3'b000, 1'b0, 12'd4), 0);
        add(0, 1, 1, 8'hFF, h1(8'h57, pd(11, 0)), 1, 4'b0001,
            {96'd0, pd(11, 0)}, 8'h57, 1, 0);

        // Reset after 3 payload DWs, then a clean length-4 completion
        quiet(1, 0, 8'hFF, h0(FT_CPLD, 10'd8, 3'b000, 1'b0, 12'd32), 0);
        quiet(1, 0, 8'hFF, h1(8'h66, pd(12, 0)), 0);
        quiet(1, 0, 8'hFF, {pd(12, 2), pd(12, 1)}, 0);
        add(1, 1, 0, 8'hFF, {pd(12, 4), pd(12, 3)}, 0, 4'h0, 128'd0, 8'h00, 0, 0);
        quiet(1, 0, 8'hFF, h0(FT_CPLD, 10'd4, 3'b000, 1'b0, 12'd16), 0);
        quiet(1, 0, 8'hFF, h1(8'h77, pd(13, 0)), 0);
        quiet(1, 0, 8'hFF, {pd(13, 2), pd(13, 1)}, 0);
        add(0, 1, 1, 8'h0F, {JUNK, pd(13, 3)}, 1, 4'b1111,
            {pd(13, 3), pd(13, 2), pd(13, 1), pd(13, 0)}, 8'h77, 1, 0);
        quiet(0, 0, 8'hFF, 64'd0, 0);

        // Reset state
        repeat (3) @(posedge i_clk);
        #1;
        check("reset valid", 128'(packer_valid), 128'd0);
        check("reset done", 128'(packer_done), 128'd0);
        check("reset err", 128'(cpl_err), 128'd0);
        check("reset dwen", 128'(packer_dout_dwen), 128'd0);
        check("reset dout", packer_dout, 128'd0);
        check("reset tag", 128'(packer_tag), 128'd0);
        check("reset tready", 128'(rx_tready), 128'd0);
        i_rst = 1'b0;
        @(posedge i_clk); #1;
        check("tready after reset", 128'(rx_tready), 128'd1);

        // Table-driven vectors
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            i_rst = v.rst; rx_tvalid = v.valid; rx_tlast = v.last; rx_tkeep = v.keep; rx_tdata = v.data;
            @(posedge i_clk); #1;
            check($sformatf("v%0d valid", i), 128'(packer_valid), 128'(v.ev));
            check($sformatf("v%0d done", i), 128'(packer_done), 128'(v.edone));
            check($sformatf("v%0d err", i), 128'(cpl_err), 128'(v.eerr));
            check($sformatf("v%0d tready", i), 128'(rx_tready), 128'(!v.rst));
            if (v.ev || v.rst) begin
                check($sformatf("v%0d dwen", i), 128'(packer_dout_dwen), 128'(v.edwen));
                check($sformatf("v%0d dout", i), packer_dout, v.edout);
                check($sformatf("v%0d tag", i), 128'(packer_tag), 128'(v.etag));
            end
        end
        i_rst = 1'b0;

        // Length 0 (1024 DWs) with byte count 0 (4096): 256 words, final
        step(1, 0, 8'hFF, h0(FT_CPLD, 10'd0, 3'b000, 1'b0, 12'd0));
        step(1, 0, 8'hFF, h1(8'h88, 32'd0));
        for (int i = 0; i < 511; i++)
            step(1, 0, 8'hFF, {32'(2 * i + 2), 32'(2 * i + 1)});
        step(1, 1, 8'h0F, {JUNK, 32'd1023});
        step(0, 0, 8'hFF, 64'd0);
        check("len1024 words", 128'(words), 128'd256);
        check("len1024 dones", 128'(dones), 128'd1);
        check("len1024 done word", 128'(done_word), 128'd255);
        check("len1024 errs", 128'(errs), 128'd0);
        check("len1024 content", 128'(content_bad), 128'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
